// File: rtl/fp16_pkg.sv
// Shared field layout, limits and state encoding for the fp16 -> sint24 converter.
package fp16_pkg;

  localparam int W_INT = 24;
  localparam int W_EXP = 5;
  localparam int W_MAN = 10;
  localparam int W_FP  = 1 + W_EXP + W_MAN;
  localparam int W_CNT = 4;

  localparam int SIGN_BIT   = 15;
  localparam int EXP_MSB    = 14;
  localparam int EXP_LSB    = 10;
  localparam int MAN_MSB    = 9;
  localparam int MAN_LSB    = 0;
  localparam int HIDDEN_POS = 10;

  localparam logic [W_EXP-1:0] EXP_ZERO      = 5'd0;
  localparam logic [W_EXP-1:0] EXP_MAX_VALID = 5'd24;
  // Exponent whose leading one already sits at HIDDEN_POS, i.e. zero shift steps.
  localparam logic [W_EXP-1:0] EXP_UNITY     = 5'd11;

  localparam logic [W_INT-1:0] INT_MAX = 24'h7FFFFF;
  localparam logic [W_INT-1:0] INT_MIN = 24'h800000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PACK,
    ST_OUT
  } state_e;

endpackage

// File: rtl/sint24_sign_sat.sv
// Applies the sign to a 24-bit magnitude and clamps the result into the sint24 range.
module sint24_sign_sat
  import fp16_pkg::*;
(
  input  logic             sign_i,
  input  logic [W_INT-1:0] mag_i,
  input  logic             ovf_i,
  output logic [W_INT-1:0] int_o,
  output logic             ovf_o
);

  // A negative magnitude of exactly 2^23 is representable, so the negative limit is inclusive.
  always_comb begin
    int_o = '0;
    ovf_o = 1'b0;
    if (!sign_i) begin
      if (ovf_i || (mag_i >= INT_MIN)) begin
        int_o = INT_MAX;
        ovf_o = 1'b1;
      end else begin
        int_o = mag_i;
      end
    end else begin
      if (ovf_i || (mag_i > INT_MIN)) begin
        int_o = INT_MIN;
        ovf_o = 1'b1;
      end else begin
        int_o = (~mag_i) + 24'd1;
      end
    end
  end

endmodule

// File: rtl/fp16_to_sint24.sv
// Iterative fp16 -> sint24 converter: one shift step per cycle, one conversion in flight,
// valid/ready handshake on both sides.
module fp16_to_sint24
  import fp16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_FP-1:0]  fp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_INT-1:0] int_out,
  output logic             out_ovf,
  output logic             out_inexact
);

  state_e             state_q;
  logic               sign_q;
  logic               bigExp_q;
  logic               dirRight_q;
  logic [W_CNT-1:0]   count_q;
  logic [W_INT-1:0]   shiftReg_q;
  logic               sticky_q;
  logic               outValid_q;
  logic [W_INT-1:0]   intOut_q;
  logic               outOvf_q;
  logic               outInexact_q;

  logic [W_EXP-1:0]   inExp;
  logic [W_MAN-1:0]   inMan;
  logic               isZero_d;
  logic               bigExp_d;
  logic               dirRight_d;
  logic [W_CNT-1:0]   count_d;
  logic [W_INT-1:0]   mag_d;
  logic               direct_d;

  logic [W_INT-1:0]   satInt;
  logic               satOvf;

  assign inExp = fp_in[EXP_MSB:EXP_LSB];
  assign inMan = fp_in[MAN_MSB:MAN_LSB];

  // Zero and out-of-range exponents load an empty magnitude and skip the shifter.
  always_comb begin
    isZero_d   = (inExp == EXP_ZERO);
    bigExp_d   = (inExp > EXP_MAX_VALID);
    dirRight_d = (inExp < EXP_UNITY);
    count_d    = dirRight_d ? W_CNT'(EXP_UNITY - inExp) : W_CNT'(inExp - EXP_UNITY);
    mag_d      = (isZero_d || bigExp_d) ? '0 : {{(W_INT-W_MAN-1){1'b0}}, 1'b1, inMan};
    direct_d   = isZero_d || bigExp_d || (count_d == '0);
  end

  sint24_sign_sat u_sign_sat (
    .sign_i (sign_q),
    .mag_i  (shiftReg_q),
    .ovf_i  (bigExp_q),
    .int_o  (satInt),
    .ovf_o  (satOvf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sign_q       <= 1'b0;
      bigExp_q     <= 1'b0;
      dirRight_q   <= 1'b0;
      count_q      <= '0;
      shiftReg_q   <= '0;
      sticky_q     <= 1'b0;
      outValid_q   <= 1'b0;
      intOut_q     <= '0;
      outOvf_q     <= 1'b0;
      outInexact_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q     <= fp_in[SIGN_BIT];
            bigExp_q   <= bigExp_d;
            dirRight_q <= dirRight_d;
            count_q    <= count_d;
            shiftReg_q <= mag_d;
            sticky_q   <= 1'b0;
            state_q    <= direct_d ? ST_PACK : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (dirRight_q) begin
            shiftReg_q <= shiftReg_q >> 1;
            sticky_q   <= sticky_q | shiftReg_q[0];
          end else begin
            shiftReg_q <= shiftReg_q << 1;
          end
          count_q <= count_q - 1'b1;
          if (count_q == W_CNT'(1)) begin
            state_q <= ST_PACK;
          end
        end
        ST_PACK: begin
          intOut_q     <= satInt;
          outOvf_q     <= satOvf;
          outInexact_q <= sticky_q;
          outValid_q   <= 1'b1;
          state_q      <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = outValid_q;
  assign int_out     = intOut_q;
  assign out_ovf     = outOvf_q;
  assign out_inexact = outInexact_q;

endmodule
